// File: rtl/fifo_ram_pkg.sv
// fifo_ram_pkg: shared constants for the fifo_ram codebase slice.
// Holds the status FSM encoding and the default word width / depth.
package fifo_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 10;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Status FSM encoding; the state port exposes these values directly.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/fifo_ram_ram_2p.sv
// ram_2p: simple dual-port storage, synchronous write, registered read.
// Contents have no reset so the array maps onto block RAM. A read and a
// write to the same address in one cycle return the old word.
module ram_2p
  import fifo_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Write port and registered read port share the single clock.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_ram.sv
// fifo_ram: synchronous FIFO on top of ram_2p with a 3-state status FSM,
// registered status flags and one-cycle overflow/underflow pulses.
// Optional build macro FIFO_THRESH_EN enables almost_full/almost_empty;
// without it both flags are tied low and AF_LEVEL/AE_LEVEL are unused.
module fifo_ram
  import fifo_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [1:0]            state
);

  localparam int                DEPTH_INT = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(DEPTH_INT);
  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic                  valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  push_acc;
  logic                  pop_acc;

  // A pop needs a stored word; a push needs room, or a same-cycle pop to
  // free one. Push+pop on empty therefore accepts only the push.
  assign pop_acc  = pop  && (state_reg != ST_EMPTY);
  assign push_acc = push && ((state_reg != ST_FULL) || pop_acc);

  // Next occupancy: moves only when exactly one side is accepted.
  always_comb begin
    count_next = count_reg;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Status FSM follows the occupancy that will hold after this edge.
  always_comb begin
    state_next = ST_PARTIAL;
    if (count_next == '0) begin
      state_next = ST_EMPTY;
    end else if (count_next == DEPTH) begin
      state_next = ST_FULL;
    end
  end

  ram_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_acc && !reset),
    .wr_addr (wr_ptr_reg),
    .wr_data (data_in),
    .rd_en   (pop_acc && !reset),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_q)
  );

  // Pointers, occupancy, FSM, read-valid and error pulses; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= ST_EMPTY;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg     <= count_next;
      state_reg     <= state_next;
      valid_reg     <= pop_acc;
      overflow_reg  <= push && !push_acc;
      underflow_reg <= pop && !pop_acc;
    end
  end

  // The RAM output register cannot be reset, so the last delivered word is
  // kept here; data_out shows it whenever no fresh read is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (valid_reg) begin
      hold_reg <= ram_q;
    end
  end

  assign data_out  = valid_reg ? ram_q : hold_reg;
  assign valid_out = valid_reg;
  assign count     = count_reg;
  assign state     = state_reg;
  assign full      = (state_reg == ST_FULL);
  assign empty     = (state_reg == ST_EMPTY);
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

`ifdef FIFO_THRESH_EN
  logic almost_full_reg;
  logic almost_empty_reg;

  // Threshold flags track the post-edge occupancy like the other flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      almost_full_reg  <= (count_next >= AF_LVL);
      almost_empty_reg <= (count_next <= AE_LVL);
    end
  end

  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
`else
  logic unused_levels;
  assign unused_levels = ^{AF_LVL, AE_LVL};
  assign almost_full   = 1'b0;
  assign almost_empty  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ram.sv
// tb_fifo_ram: directed bench for fifo_ram at default parameters.
// Expected values come from hand-written constants plus a small queue
// reference; threshold expectations follow the FIFO_THRESH_EN build macro.
module tb_fifo_ram;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef FIFO_THRESH_EN
  localparam bit THRESH = 1'b1;
`else
  localparam bit THRESH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;

  fifo_ram dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every output against the reference after an edge.
  task automatic check_all();
    int n;
    n = model_q.size();
    check_eq("data_out", data_out, exp_dout);
    check_eq("valid_out", valid_out, exp_valid);
    check_eq("count", count, n);
    check_eq("empty", empty, n == 0);
    check_eq("full", full, n == DEPTH);
    check_eq("state", state, (n == 0) ? 0 : ((n == DEPTH) ? 2 : 1));
    check_eq("almost_full", almost_full, THRESH && (n >= 6));
    check_eq("almost_empty", almost_empty, THRESH && (n <= 2));
    check_eq("overflow", overflow, exp_ovf);
    check_eq("underflow", underflow, exp_unf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%0b push=%0b pop=%0b din=%03h -> dout=%03h vld=%0b cnt=%0d st=%0d ovf=%0b unf=%0b af=%0b ae=%0b",
             cyc, reset, push, pop, data_in, data_out, valid_out, count, state, overflow, underflow,
             almost_full, almost_empty);
  endtask

  // One normal cycle with push/pop requests, reference updated first.
  task automatic cycle(input logic p, input logic o, input logic [DW-1:0] d);
    bit ep;
    bit epush;
    reset   = 1'b0;
    push    = p;
    pop     = o;
    data_in = d;
    ep      = o && (model_q.size() != 0);
    epush   = p && ((model_q.size() < DEPTH) || ep);
    exp_ovf = p && !epush;
    exp_unf = o && !ep;
    exp_valid = ep;
    if (ep) exp_dout = model_q.pop_front();
    if (epush) model_q.push_back(d);
    tick();
    check_all();
  endtask

  // Reset cycle, optionally with a push request that must be ignored.
  task automatic reset_cycle(input logic p, input logic [DW-1:0] d);
    reset     = 1'b1;
    push      = p;
    pop       = 1'b0;
    data_in   = d;
    model_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    tick();
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] words [4];
    words[0] = 10'h3FF; words[1] = 10'h2AA; words[2] = 10'h155; words[3] = 10'h3E0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;

    // Reset state.
    reset_cycle(1'b0, '0);
    reset_cycle(1'b0, '0);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ae", almost_empty, THRESH);

    // Four pushes, four pops, in order with one-cycle read latency.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, words[i]);
    check_eq("cnt_after_4", count, 4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0);
      check_eq("pop_word", data_out, words[i]);
      check_eq("pop_cnt", count, 3 - i);
    end
    check_eq("back_empty", state, 0);
    cycle(1'b0, 1'b0, '0);
    check_eq("hold_dout", data_out, 10'h3E0);

    // Pop on empty, then push+pop on empty.
    cycle(1'b0, 1'b1, '0);
    check_eq("unf_pulse", underflow, 1);
    check_eq("unf_dout", data_out, 10'h3E0);
    cycle(1'b0, 1'b0, '0);
    check_eq("unf_cleared", underflow, 0);
    cycle(1'b1, 1'b1, 10'h011);
    check_eq("pp_empty_cnt", count, 1);
    check_eq("pp_empty_unf", underflow, 1);
    cycle(1'b0, 1'b1, '0);
    check_eq("pp_empty_word", data_out, 10'h011);

    // Fill past full: ninth push overflows.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 10'(10'h100 + i));
    check_eq("ovf_pulse", overflow, 1);
    check_eq("ovf_cnt", count, 8);
    check_eq("ovf_full", full, 1);

    // Full with simultaneous push+pop across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 10'(10'h200 + k));
      if (k < 8) check_eq("wrap_first8", data_out, 10'(10'h100 + k));
    end
    check_eq("wrap_state", state, 2);

    // Drain; threshold flags are checked at every count on the way down.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
    check_eq("drain_last", data_out, 10'h209);

    // Reset with push pending at count 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 10'(10'h050 + i));
    check_eq("pre_rst_cnt", count, 5);
    reset_cycle(1'b1, 10'h077);
    check_eq("rst_push_cnt", count, 0);
    check_eq("rst_push_dout", data_out, 0);
    cycle(1'b0, 1'b1, '0);
    check_eq("rst_no_write", underflow, 1);
    cycle(1'b1, 1'b0, 10'h0AB);
    cycle(1'b0, 1'b1, '0);
    check_eq("post_rst_word", data_out, 10'h0AB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ram.md
FIFO_RAM -- requirements
Module: fifo_ram

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 10, word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 3, storage depth 2**ADDR_WIDTH words.
REQ-003 SHALL provide parameter AF_LEVEL, default 6, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  word to store.
REQ-008 SHALL have port push  input  1  write request.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  registered read word.
REQ-011 SHALL have port valid_out  output  1  data_out updated this cycle.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have port count  output  ADDR_WIDTH+1  words stored.
REQ-014 SHALL have ports overflow, underflow  output  1 each  one-cycle error pulses.
REQ-015 SHALL have port state  output  2  status FSM state.

Function
REQ-016 Push accepted when !full, or when full and a pop is accepted the same cycle; accepted word written at write pointer.
REQ-017 Pop accepted when !empty; word at read pointer appears on data_out exactly one cycle later, with valid_out high for that one cycle.
REQ-018 data_out SHALL hold its last value when no pop is accepted.
REQ-019 Push and pop on an empty FIFO: push accepted; pop rejected with underflow pulse (no fall-through).
REQ-020 Push without pop on a full FIFO: word dropped; overflow pulse next cycle; contents unchanged.
REQ-021 Pop on an empty FIFO: underflow pulse next cycle; data_out unchanged; valid_out low.
REQ-022 Pointers SHALL wrap modulo 2**ADDR_WIDTH; count SHALL range 0..2**ADDR_WIDTH and never wrap.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and hold on both-accepted or neither.
REQ-024 FSM states: EMPTY (count 0), PARTIAL (0 < count < depth), FULL (count = depth). Transitions: EMPTY->PARTIAL on accepted push; PARTIAL->FULL when count reaches depth; PARTIAL->EMPTY when count reaches 0; FULL->PARTIAL on pop-only.
REQ-025 full SHALL equal (state==FULL) and empty SHALL equal (state==EMPTY); all flags SHALL be registered and reflect count after the current edge.

Reset
REQ-026 Reset SHALL take priority over push/pop in the same cycle.
REQ-027 Reset values: pointers 0, count 0, state EMPTY, empty 1, almost_empty 1 (when enabled), full 0, almost_full 0, data_out 0, valid_out 0, overflow 0, underflow 0.
REQ-028 Storage contents SHALL NOT be cleared by reset; they are unreadable until rewritten.

Configuration
REQ-029 With macro FIFO_THRESH_EN defined, almost_full and almost_empty SHALL follow REQ-003/REQ-004; without it, both SHALL be tied to 0 and AF_LEVEL/AE_LEVEL ignored.

Structure
REQ-030 Package fifo_ram_pkg SHALL hold the FSM state encoding (EMPTY=0, PARTIAL=1, FULL=2) and default width/depth constants.
REQ-031 Storage SHALL be sub-module ram_2p: simple dual-port, synchronous write, registered read, parametrised by DATA_WIDTH/ADDR_WIDTH.

Verification (defaults, FIFO_THRESH_EN defined)
REQ-032 After reset, push 'h3FF,'h2AA,'h155,'h3E0 on consecutive cycles, then 4 pops -> data_out 'h3FF,'h2AA,'h155,'h3E0, each 1 cycle after its pop; count 4->0; state returns to EMPTY.
REQ-033 Push 9 words without pop -> full=1 after 8th push; 9th push produces overflow pulse; count stays 8; reading back returns the first 8 words.
REQ-034 Pop on empty -> underflow pulse, valid_out 0, data_out unchanged; simultaneous push+pop on empty -> count 1, underflow pulse.
REQ-035 Full FIFO with simultaneous push+pop for 10 cycles -> count stays 8, state FULL, output order preserved across pointer wrap.
REQ-036 Threshold sweep: count 2->almost_empty 1, 3->0; count 6->almost_full 1, 5->0; rebuilt without FIFO_THRESH_EN -> both 0 throughout.
REQ-037 Reset asserted with push=1 at count 5 -> next cycle count 0, empty 1, data_out 0, no write accepted.
